bus_arbiter7: RTL and testbench

Registered fixed-priority arbiter that shares one 8-bit tristate data bus among up to seven `drive8` bus drivers. It issues one-hot drive grants, and each grant bit connects directly to the `e` input of one driver. A mandatory one-cycle turnaround between owners keeps any two drivers from being enabled in the same cycle. A hold limit with a one-shot mask stops a single requester from monopolising the bus.

---
 rtl/bus_arbiter7.sv | 110 +++++++++++
 tb/tb_bus_arbiter7.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter7.sv
// Registered fixed-priority arbiter sharing one tristate byte bus among seven drivers.
// One-hot grants feed the driver enables directly; a turnaround cycle separates owners.
module bus_arbiter7 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:1] req,
    output logic [7:1] gnt,
    output logic [2:0] owner,
    output logic       busy,
    output logic       timeout
);

    localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e     state_q, state_d;
    logic [7:1] gnt_q, gnt_d;
    logic [7:1] mask_q, mask_d;
    logic [7:1] cand;
    logic [2:0] owner_q, owner_d;
    logic [2:0] winner;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       busy_q;

    // A masked requester that is alone still wins, so no cycle is wasted.
    always_comb begin
        cand = req & ~mask_q;
        if (cand == '0) begin
            cand = req;
        end
        winner = '0;
        for (int i = 7; i >= 1; i--) begin
            if (cand[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StGrant: begin
                // gnt is one-hot, so this picks out req[owner].
                if ((req & gnt_q) == '0) begin
                    state_d = StTurn;
                    gnt_d   = '0;
                    owner_d = '0;
                end else if (cnt_q == HoldMax) begin
                    state_d   = StTurn;
                    gnt_d     = '0;
                    owner_d   = '0;
                    mask_d    = gnt_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (state_q == StTurn) begin
                    mask_d = '0;
                end
                if (winner != '0) begin
                    state_d = StGrant;
                    owner_d = winner;
                    cnt_d   = 8'd1;
                    for (int j = 1; j <= 7; j++) begin
                        gnt_d[j] = (winner == 3'(j));
                    end
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter7.sv
// Directed bench for bus_arbiter7: one instance with MAX_HOLD=4, one with MAX_HOLD=1,
// plus a continuous one-hot / no-direct-handoff monitor on both grant buses.
module tb_bus_arbiter7;

    logic       clk;
    logic       rst;
    logic [7:1] req_a, req_b;
    logic [7:1] gnt_a, gnt_b;
    logic [2:0] owner_a, owner_b;
    logic       busy_a, busy_b;
    logic       timeout_a, timeout_b;

    int total = 0;
    int bad   = 0;

    bus_arbiter7 #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a),
        .owner(owner_a), .busy(busy_a), .timeout(timeout_a)
    );

    bus_arbiter7 #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b),
        .owner(owner_b), .busy(busy_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:1] oh(input int i);
        logic [7:1] r;
        for (int j = 1; j <= 7; j++) r[j] = (j == i);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant must be zero or one-hot, owner must match it, and no direct owner swap.
    logic [7:1] prev_a = '0, prev_b = '0;
    always @(negedge clk) begin
        if (!rst) begin
            check("onehot_a", {31'd0, $onehot0(gnt_a)}, 32'd1);
            check("onehot_b", {31'd0, $onehot0(gnt_b)}, 32'd1);
            check("owner_vs_gnt_a", {25'd0, gnt_a}, {25'd0, (owner_a == 0) ? 7'd0 : oh(owner_a)});
            check("swap_a", {31'd0, (prev_a != 0 && gnt_a != 0 && prev_a != gnt_a)}, 32'd0);
            check("swap_b", {31'd0, (prev_b != 0 && gnt_b != 0 && prev_b != gnt_b)}, 32'd0);
        end
        prev_a = gnt_a;
        prev_b = gnt_b;
    end

    initial begin
        rst   = 1'b1;
        req_a = 7'h7F;
        req_b = '0;

        // Reset held with every request asserted.
        tick();
        tick();
        check("rst_gnt", {25'd0, gnt_a}, 32'd0);
        check("rst_owner", {29'd0, owner_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_timeout", {31'd0, timeout_a}, 32'd0);
        rst = 1'b0;
        tick();
        check("first_gnt", {25'd0, gnt_a}, {25'd0, 7'b0000001});
        check("first_owner", {29'd0, owner_a}, 32'd1);
        check("first_busy", {31'd0, busy_a}, 32'd1);
        req_a = '0;
        tick();
        check("first_turn_gnt", {25'd0, gnt_a}, 32'd0);
        check("first_turn_busy", {31'd0, busy_a}, 32'd1);
        tick();
        check("first_idle_busy", {31'd0, busy_a}, 32'd0);

        // Priority and handoff.
        req_a = oh(3) | oh(5);
        tick();
        check("prio_owner", {29'd0, owner_a}, 32'd3);
        check("prio_gnt", {25'd0, gnt_a}, {25'd0, 7'b0000100});
        req_a = oh(5);
        tick();
        check("hand_turn_gnt", {25'd0, gnt_a}, 32'd0);
        check("hand_turn_timeout", {31'd0, timeout_a}, 32'd0);
        check("hand_turn_owner", {29'd0, owner_a}, 32'd0);
        tick();
        check("hand_owner", {29'd0, owner_a}, 32'd5);
        check("hand_gnt", {25'd0, gnt_a}, {25'd0, 7'b0010000});
        req_a = '0;
        tick();
        tick();
        check("hand_idle", {31'd0, busy_a}, 32'd0);

        // Hold limit with a lower-priority waiter.
        req_a = oh(2) | oh(6);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("wait_hold%0d", k), {25'd0, gnt_a}, {25'd0, 7'b0000010});
            check($sformatf("wait_hold_to%0d", k), {31'd0, timeout_a}, 32'd0);
        end
        tick();
        check("wait_turn_gnt", {25'd0, gnt_a}, 32'd0);
        check("wait_turn_timeout", {31'd0, timeout_a}, 32'd1);
        tick();
        check("wait_owner6", {29'd0, owner_a}, 32'd6);
        check("wait_owner6_to", {31'd0, timeout_a}, 32'd0);
        req_a = oh(2);
        tick();
        check("wait_turn2_gnt", {25'd0, gnt_a}, 32'd0);
        check("wait_turn2_timeout", {31'd0, timeout_a}, 32'd0);
        tick();
        check("wait_owner2", {29'd0, owner_a}, 32'd2);
        req_a = '0;
        tick();
        tick();
        check("wait_idle", {31'd0, busy_a}, 32'd0);

        // Sole requester hitting the hold limit: period 5.
        req_a = oh(4);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                check($sformatf("sole_p%0d_hold%0d", p, k), {25'd0, gnt_a}, {25'd0, 7'b0001000});
            end
            tick();
            check($sformatf("sole_p%0d_turn", p), {25'd0, gnt_a}, 32'd0);
            check($sformatf("sole_p%0d_to", p), {31'd0, timeout_a}, 32'd1);
        end
        req_a = '0;
        tick();
        check("sole_idle_busy", {31'd0, busy_a}, 32'd0);
        check("sole_idle_gnt", {25'd0, gnt_a}, 32'd0);

        // Reset while owner 7 holds the bus.
        req_a = oh(7);
        tick();
        check("rmid_owner", {29'd0, owner_a}, 32'd7);
        tick();
        rst = 1'b1;
        tick();
        check("rmid_gnt", {25'd0, gnt_a}, 32'd0);
        check("rmid_owner0", {29'd0, owner_a}, 32'd0);
        check("rmid_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        tick();
        check("rmid_regrant", {25'd0, gnt_a}, {25'd0, 7'b1000000});
        check("rmid_regrant_owner", {29'd0, owner_a}, 32'd7);
        req_a = '0;
        tick();
        tick();

        // Single-cycle request pulse.
        req_a = oh(1);
        tick();
        req_a = '0;
        check("pulse_gnt", {25'd0, gnt_a}, {25'd0, 7'b0000001});
        tick();
        check("pulse_turn_gnt", {25'd0, gnt_a}, 32'd0);
        check("pulse_turn_busy", {31'd0, busy_a}, 32'd1);
        tick();
        check("pulse_idle_busy", {31'd0, busy_a}, 32'd0);
        check("pulse_idle_gnt", {25'd0, gnt_a}, 32'd0);

        // MAX_HOLD=1: grant for one cycle, then a timeout turnaround, then regrant.
        req_b = oh(3);
        tick();
        check("h1_gnt", {25'd0, gnt_b}, {25'd0, 7'b0000100});
        tick();
        check("h1_turn_gnt", {25'd0, gnt_b}, 32'd0);
        check("h1_turn_to", {31'd0, timeout_b}, 32'd1);
        tick();
        check("h1_regrant", {25'd0, gnt_b}, {25'd0, 7'b0000100});
        check("h1_regrant_to", {31'd0, timeout_b}, 32'd0);
        req_b = '0;
        tick();
        tick();
        check("h1_idle", {31'd0, busy_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
